// File: rtl/imem_fetch_unit_pkg.sv
// Shared types and constants for the instruction-memory fetch unit.
package imem_pkg;

    typedef logic [31:0] instr_t;

    // Word returned in place of real data for a faulting fetch.
    localparam instr_t NOP_INSTR = 32'h0000_0000;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } imem_state_t;

endpackage

// File: rtl/imem_byte_ram.sv
// Byte-wide storage with one byte write port and a registered 4-byte read
// port returning lanes a..a+3 packed little-endian. Lanes past the end of
// storage read as zero, so out-of-range fetches never index outside the array.
module imem_byte_ram
    import imem_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output instr_t            rdata
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] LIM = (ADDR_W+1)'(DEPTH);

    logic [7:0]       mem [DEPTH];
    logic [3:0][7:0]  lane;
    logic [ADDR_W:0]  wext;

    assign wext = {1'b0, waddr};

    // Byte write; addresses beyond storage are dropped.
    always_ff @(posedge clk) begin
        if (we && (wext < LIM))
            mem[waddr[IDX_W-1:0]] <= wdata;
    end

    for (genvar i = 0; i < 4; i++) begin : g_lane
        logic [ADDR_W:0] la;
        assign la      = {1'b0, raddr} + (ADDR_W+1)'(i);
        assign lane[i] = (la < LIM) ? mem[la[IDX_W-1:0]] : 8'h00;
    end

    // Read register only advances on an accepted fetch, so it holds under back-pressure.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rdata <= '0;
        else if (re)
            rdata <= lane;
    end

endmodule

// File: rtl/imem_fetch_unit.sv
// Instruction memory with a byte loader and a valid/ready word-fetch port.
// LOAD fills storage; RUN serves fetches through a one-entry response
// register that passes through at full rate when the consumer is ready.
module imem_fetch_unit
    import imem_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    input  logic              ld_done,
    output logic              running,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_instr,
    output logic              rsp_fault
);

    localparam logic [ADDR_W:0] LIM = (ADDR_W+1)'(DEPTH);

    imem_state_t     state, state_next;
    logic            accept;
    logic            fault_c;
    logic [ADDR_W:0] end_addr;
    instr_t          rd_word;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= LOAD;
        else
            state <= state_next;
    end

    // Next state: LOAD leaves on ld_done; RUN is only left through reset.
    always_comb begin
        state_next = state;
        if (state == LOAD && ld_done)
            state_next = RUN;
    end

    assign running   = (state == RUN);
    assign req_ready = running && (!rsp_valid || rsp_ready);
    assign accept    = req_valid && req_ready;

    // Last byte address computed one bit wider so it cannot wrap.
    assign end_addr = {1'b0, req_addr} + (ADDR_W+1)'(3);
    assign fault_c  = (req_addr[1:0] != 2'b00) || (end_addr >= LIM);

    imem_byte_ram #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (ld_en && (state == LOAD)),
        .waddr (ld_addr),
        .wdata (ld_data),
        .re    (accept),
        .raddr (req_addr),
        .rdata (rd_word)
    );

    // Response register: load on accept, drain when consumed, otherwise hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_fault <= 1'b0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_fault <= fault_c;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    assign rsp_instr = rsp_fault ? NOP_INSTR : rd_word;

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Directed plus randomized bench for imem_fetch_unit against a byte-array model.
module tb_imem_fetch_unit;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;

    logic              clk = 1'b0;
    logic              reset;
    logic              ld_en, ld_done, running;
    logic [ADDR_W-1:0] ld_addr, req_addr;
    logic [7:0]        ld_data;
    logic              req_valid, req_ready, rsp_valid, rsp_ready, rsp_fault;
    logic [31:0]       rsp_instr;

    int checks   = 0;
    int failures = 0;

    logic [7:0] ref_mem [DEPTH];

    imem_fetch_unit #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .ld_done   (ld_done),
        .running   (running),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_instr (rsp_instr),
        .rsp_fault (rsp_fault)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference fetch: {fault, word} straight from the addressing rules.
    function automatic logic [32:0] model_fetch(input int a);
        if ((a % 4) != 0 || (a + 3) >= DEPTH)
            return {1'b1, 32'h0};
        return {1'b0, ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
    endfunction

    logic [7:0]  prog [16];
    logic [31:0] prog_words [4];
    logic [32:0] mres;
    logic        m_valid, m_fault, rv, rr, acc;
    logic [31:0] m_instr;
    int          a;

    initial begin
        prog = '{8'h02, 8'h00, 8'h08, 8'h21, 8'h20, 8'h40, 8'h0a, 8'h01,
                 8'h00, 8'h00, 8'h28, 8'had, 8'h01, 8'h00, 8'h00, 8'h08};
        prog_words = '{32'h21080002, 32'h010a4020, 32'had280000, 32'h08000001};

        reset = 1'b1; ld_en = 0; ld_addr = '0; ld_data = '0; ld_done = 0;
        req_valid = 0; req_addr = '0; rsp_ready = 0;
        #2;
        chk("reset_running",   32'(running),   32'd0);
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_instr", rsp_instr,      32'd0);
        chk("reset_rsp_fault", 32'(rsp_fault), 32'd0);
        tick; tick;
        reset = 1'b0;
        tick;

        // Load all bytes with a pending request; last byte shares its cycle with ld_done.
        req_valid = 1'b1; rsp_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i] = (i < 16) ? prog[i] : 8'($urandom_range(0, 255));
            ld_en = 1'b1; ld_addr = ADDR_W'(i); ld_data = ref_mem[i];
            ld_done = (i == DEPTH - 1);
            #1;
            if (i == 100) begin
                chk("load_req_ready", 32'(req_ready), 32'd0);
                chk("load_running",   32'(running),   32'd0);
            end
            tick;
            if (i == 100) chk("load_no_rsp", 32'(rsp_valid), 32'd0);
        end
        ld_en = 0; ld_done = 0; req_valid = 0;
        #1;
        chk("run_running",   32'(running),   32'd1);
        chk("run_req_ready", 32'(req_ready), 32'd1);

        // Back-to-back fetch of the program words.
        for (int k = 0; k < 4; k++) begin
            req_valid = 1'b1; req_addr = ADDR_W'(4 * k);
            tick;
            chk("b2b_valid", 32'(rsp_valid), 32'd1);
            chk("b2b_instr", rsp_instr,      prog_words[k]);
            chk("b2b_fault", 32'(rsp_fault), 32'd0);
        end

        // Misaligned and end-of-memory boundary.
        req_addr = 8'd5; tick;
        chk("misal_fault", 32'(rsp_fault), 32'd1);
        chk("misal_instr", rsp_instr,      32'd0);
        req_addr = 8'd252; tick;
        mres = model_fetch(252);
        chk("top_fault", 32'(rsp_fault), 32'd0);
        chk("top_instr", rsp_instr,      mres[31:0]);
        req_addr = 8'd253; tick;
        chk("top_misal_fault", 32'(rsp_fault), 32'd1);
        chk("top_misal_instr", rsp_instr,      32'd0);

        // Back-pressure after a fetch of 4.
        req_addr = 8'd4; tick;
        rsp_ready = 1'b0; req_addr = 8'd8;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            tick;
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_instr", rsp_instr,      32'h010a4020);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(req_ready), 32'd1);
        tick;
        chk("bp_next_instr", rsp_instr, 32'had280000);
        req_valid = 1'b0;
        tick;
        chk("drain_valid", 32'(rsp_valid), 32'd0);

        // Randomized traffic against a handshake/storage model.
        m_valid = 1'b0; m_fault = 1'b0; m_instr = '0;
        for (int n = 0; n < 400; n++) begin
            rv = 1'($urandom_range(0, 1));
            rr = ($urandom_range(0, 3) != 0);
            a  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                             : 4 * int'($urandom_range(0, 63));
            req_valid = rv; rsp_ready = rr; req_addr = ADDR_W'(a);
            #1;
            chk("rnd_req_ready", 32'(req_ready), 32'(!m_valid || rr));
            acc = rv && (!m_valid || rr);
            tick;
            if (acc) begin
                mres = model_fetch(a);
                m_valid = 1'b1; m_fault = mres[32]; m_instr = mres[31:0];
            end else if (rr) begin
                m_valid = 1'b0;
            end
            chk("rnd_valid", 32'(rsp_valid), 32'(m_valid));
            if (m_valid) begin
                chk("rnd_instr", rsp_instr,      m_instr);
                chk("rnd_fault", 32'(rsp_fault), 32'(m_fault));
            end
        end
        req_valid = 0; rsp_ready = 1'b1;
        tick;

        // Loader is ignored in RUN.
        ld_en = 1'b1; ld_addr = 8'd0; ld_data = 8'hFF; ld_done = 1'b1;
        tick;
        ld_en = 0; ld_done = 0;
        chk("run_stays", 32'(running), 32'd1);
        req_valid = 1'b1; req_addr = 8'd0;
        tick;
        req_valid = 1'b0;
        chk("run_write_ignored", rsp_instr, 32'h21080002);

        // Reset while a response is pending.
        req_valid = 1'b1; req_addr = 8'd4;
        tick;
        req_valid = 1'b0; rsp_ready = 1'b0;
        chk("pre_reset_valid", 32'(rsp_valid), 32'd1);
        reset = 1'b1;
        #1;
        chk("async_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("async_running",   32'(running),   32'd0);
        chk("async_req_ready", 32'(req_ready), 32'd0);
        tick;
        reset = 1'b0;
        rsp_ready = 1'b1;
        tick;
        chk("post_reset_load", 32'(running), 32'd0);
        ld_done = 1'b1;
        tick;
        ld_done = 1'b0;
        chk("reload_running", 32'(running), 32'd1);
        req_valid = 1'b1; req_addr = 8'd0;
        tick;
        req_valid = 1'b0;
        chk("retained_valid", 32'(rsp_valid), 32'd1);
        chk("retained_instr", rsp_instr,      32'h21080002);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
